// File: rtl/multi_cycle.sv
// multi_cycle: multi-cycle RV32I core sharing one instruction/data memory port.
// Each instruction walks FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK].
// Illegal encodings, ECALL/EBREAK and misaligned accesses park the core in TRAP
// until reset.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   mem_req/mem_we    request valid / request is a write
//   mem_addr          byte address of the request
//   mem_byte_en       byte-lane enables
//   mem_wdata         lane-replicated store data
//   mem_ready         memory accepts/completes the request this cycle
//   mem_rdata         read data, valid with mem_req && mem_ready && !mem_we
//   pc, instruction   current instruction address / latched instruction
//   state             FSM state code (FETCH=0 .. TRAP=5)
//   retire            one-cycle pulse in the final cycle of an instruction
//   trap              high while in TRAP
module multi_cycle #(
    parameter int unsigned        XLEN         = 32,
    parameter logic [XLEN-1:0]    RESET_VECTOR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_byte_en,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instruction,
    output logic [2:0]      state,
    output logic            retire,
    output logic            trap
);

    if (XLEN != 32) begin : g_xlen_check
        $error("multi_cycle supports only XLEN=32");
    end

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    state_t cur_state, nxt_state;

    logic [31:0] op_a, op_b, imm_q, alu_out, load_data;
    // Entry 0 is cleared by reset and never written, so it always reads as x0.
    logic [31:0] regs [32];

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_op;
    logic       legal, taken, misaligned;
    logic [31:0] imm_dec, alu_b, alu_res, exec_res, lane, load_ext, wb_data;

    assign state  = cur_state;
    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_op     = (opcode == OP_OP);

    // SYSTEM and MISC-MEM opcodes fall through to illegal.
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
            OP_JALR:   legal = (funct3 == 3'b000);
            OP_BRANCH: legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            OP_LOAD:   legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            OP_STORE:  legal = (funct3 < 3'b011);
            OP_IMM: begin
                if (funct3 == 3'b001)
                    legal = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101)
                    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else
                    legal = 1'b1;
            end
            OP_OP: legal = (funct7 == 7'b0000000) ||
                           ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        imm_dec = '0;
        case (opcode)
            OP_LUI, OP_AUIPC: imm_dec = {instruction[31:12], 12'b0};
            OP_JAL:    imm_dec = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                                  instruction[30:21], 1'b0};
            OP_BRANCH: imm_dec = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                                  instruction[11:8], 1'b0};
            OP_STORE:  imm_dec = {{21{instruction[31]}}, instruction[30:25], instruction[11:7]};
            default:   imm_dec = {{21{instruction[31]}}, instruction[30:20]};
        endcase
    end

    // instruction[30] selects SUB/SRA for register ops and SRAI for immediates.
    always_comb begin
        alu_b   = is_op ? op_b : imm_q;
        alu_res = '0;
        case (funct3)
            3'b000: alu_res = (is_op && funct7[5]) ? op_a - alu_b : op_a + alu_b;
            3'b001: alu_res = op_a << alu_b[4:0];
            3'b010: alu_res = {31'b0, $signed(op_a) < $signed(alu_b)};
            3'b011: alu_res = {31'b0, op_a < alu_b};
            3'b100: alu_res = op_a ^ alu_b;
            3'b101: alu_res = funct7[5] ? $unsigned($signed(op_a) >>> alu_b[4:0])
                                        : op_a >> alu_b[4:0];
            3'b110: alu_res = op_a | alu_b;
            default: alu_res = op_a & alu_b;
        endcase
    end

    always_comb begin
        if (is_lui)
            exec_res = imm_q;
        else if (is_auipc || is_jal)
            exec_res = pc + imm_q;
        else if (is_jalr || is_load || is_store)
            exec_res = op_a + imm_q;
        else
            exec_res = alu_res;
    end

    always_comb begin
        case (funct3)
            3'b000:  taken = (op_a == op_b);
            3'b001:  taken = (op_a != op_b);
            3'b100:  taken = ($signed(op_a) < $signed(op_b));
            3'b101:  taken = ($signed(op_a) >= $signed(op_b));
            3'b110:  taken = (op_a < op_b);
            3'b111:  taken = (op_a >= op_b);
            default: taken = 1'b0;
        endcase
    end

    // funct3[1:0] encodes access size for both loads and stores.
    always_comb begin
        case (funct3[1:0])
            2'b01:   misaligned = exec_res[0];
            2'b10:   misaligned = (exec_res[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        lane = mem_rdata >> {alu_out[1:0], 3'b000};
        case (funct3)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'b0, lane[7:0]};
            3'b101:  load_ext = {16'b0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        if (is_load)
            wb_data = load_data;
        else if (is_jal || is_jalr)
            wb_data = pc + 32'd4;
        else
            wb_data = alu_out;
    end

    always_comb begin
        nxt_state   = cur_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = pc;
        mem_byte_en = 4'b1111;
        mem_wdata   = '0;
        retire      = 1'b0;
        trap        = 1'b0;
        case (cur_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready)
                    nxt_state = S_DECODE;
            end
            S_DECODE: nxt_state = legal ? S_EXECUTE : S_TRAP;
            S_EXECUTE: begin
                if (is_branch) begin
                    retire    = 1'b1;
                    nxt_state = S_FETCH;
                end else if (is_load || is_store) begin
                    nxt_state = misaligned ? S_TRAP : S_MEMORY;
                end else begin
                    nxt_state = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                mem_req  = 1'b1;
                mem_addr = alu_out;
                mem_we   = is_store;
                if (is_store) begin
                    case (funct3[1:0])
                        2'b00: begin
                            mem_wdata   = {4{op_b[7:0]}};
                            mem_byte_en = 4'b0001 << alu_out[1:0];
                        end
                        2'b01: begin
                            mem_wdata   = {2{op_b[15:0]}};
                            mem_byte_en = 4'b0011 << alu_out[1:0];
                        end
                        default: mem_wdata = op_b;
                    endcase
                end
                if (mem_ready) begin
                    retire    = is_store;
                    nxt_state = is_store ? S_FETCH : S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                retire    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_TRAP: trap = 1'b1;
            default: nxt_state = S_FETCH;
        endcase
        // State already sits at FETCH during reset; keep the port quiet.
        if (reset)
            mem_req = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state   <= S_FETCH;
            pc          <= RESET_VECTOR;
            instruction <= '0;
            op_a        <= '0;
            op_b        <= '0;
            imm_q       <= '0;
            alu_out     <= '0;
            load_data   <= '0;
        end else begin
            cur_state <= nxt_state;
            case (cur_state)
                S_FETCH: if (mem_ready) instruction <= mem_rdata;
                S_DECODE: begin
                    op_a  <= regs[rs1];
                    op_b  <= regs[rs2];
                    imm_q <= imm_dec;
                end
                S_EXECUTE: begin
                    alu_out <= exec_res;
                    if (is_branch)
                        pc <= taken ? pc + imm_q : pc + 32'd4;
                end
                S_MEMORY: begin
                    if (mem_ready) begin
                        if (is_store)
                            pc <= pc + 32'd4;
                        else
                            load_data <= load_ext;
                    end
                end
                S_WRITEBACK: begin
                    if (is_jal)
                        pc <= alu_out;
                    else if (is_jalr)
                        pc <= {alu_out[31:1], 1'b0};
                    else
                        pc <= pc + 32'd4;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (cur_state == S_WRITEBACK && rd != 5'd0) begin
            regs[rd] <= wb_data;
        end
    end

endmodule

// File: tb/tb_multi_cycle.sv
module tb_multi_cycle;

    localparam int OPC_IMM  = 'h13;
    localparam int OPC_LOAD = 'h03;
    localparam int OPC_JALR = 'h67;
    localparam int OPC_LUI  = 'h37;

    logic        clk, reset;
    logic        mem_req, mem_we, mem_ready, retire, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, instruction;
    logic [3:0]  mem_byte_en;
    logic [2:0]  state;

    logic [31:0] mem [256];
    int fetch_delay, data_delay, wait_cnt;
    int total = 0;
    int bad   = 0;

    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        m_we;
    bit          addr_moved;

    multi_cycle #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .pc(pc), .instruction(instruction), .state(state),
        .retire(retire), .trap(trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: decides ready on the falling edge, counting wait cycles
    // per request; writes land when ready is granted.
    always @(negedge clk) begin
        if (reset || !mem_req) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end else if (wait_cnt < ((state == 3'd3) ? data_delay : fetch_delay)) begin
            mem_ready = 1'b0;
            wait_cnt++;
        end else begin
            mem_ready = 1'b1;
            wait_cnt  = 0;
            mem_rdata = mem[mem_addr[9:2]];
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_byte_en[b])
                        mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end
    end

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1,
                                          input int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                          input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction

    task automatic begin_test();
        @(posedge clk); #1;
        reset       = 1'b1;
        fetch_delay = 0;
        data_delay  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Returns one cycle after the retire edge so pc/rd already hold new values.
    task automatic wait_retire(input int max_cycles, output int cycles);
        bit seen;
        bit mem_seen;
        seen = 0; mem_seen = 0; cycles = 0; addr_moved = 0;
        m_addr = '1; m_wdata = '0; m_be = '0; m_we = 1'b0;
        while (!seen && cycles < max_cycles) begin
            @(negedge clk); #1;
            cycles++;
            if (state == 3'd3 && mem_req) begin
                if (mem_seen && mem_addr !== m_addr) addr_moved = 1;
                m_addr = mem_addr; m_wdata = mem_wdata; m_be = mem_byte_en; m_we = mem_we;
                mem_seen = 1;
            end
            if (retire === 1'b1) seen = 1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL retire_timeout got=none want=retire within %0d cycles", max_cycles);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b want=0", mem_req); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=00000000", pc); end
        total++; if (instruction !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=00000000", instruction); end
        total++; if (retire !== 1'b0 || trap !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b want=00", retire, trap); end
    endtask

    task automatic test_addi();
        int cyc;
        begin_test();
        mem[0] = enc_i(5, 0, 0, 1, OPC_IMM);
        release_reset();
        wait_retire(20, cyc);
        total++; if (cyc != 4) begin bad++; $display("FAIL addi_cycles got=%0d want=4", cyc); end
        total++; if (dut.regs[1] !== 32'd5) begin bad++; $display("FAIL addi_x1 got=%h want=00000005", dut.regs[1]); end
        total++; if (pc !== 32'h4) begin bad++; $display("FAIL addi_pc got=%h want=00000004", pc); end
    endtask

    task automatic test_load_delay();
        int cyc;
        begin_test();
        mem[0] = enc_i('h100, 0, 0, 1, OPC_IMM);
        mem[1] = enc_i(0, 1, 2, 2, OPC_LOAD);
        mem['h40] = 32'hDEAD_BEEF;
        data_delay = 3;
        release_reset();
        wait_retire(20, cyc);
        wait_retire(30, cyc);
        total++; if (cyc != 8) begin bad++; $display("FAIL lw_cycles got=%0d want=8", cyc); end
        total++; if (m_addr !== 32'h100 || addr_moved) begin bad++; $display("FAIL lw_addr got=%h moved=%b want=00000100 moved=0", m_addr, addr_moved); end
        total++; if (m_we !== 1'b0) begin bad++; $display("FAIL lw_we got=%b want=0", m_we); end
        total++; if (dut.regs[2] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_x2 got=%h want=deadbeef", dut.regs[2]); end
        total++; if (pc !== 32'h8) begin bad++; $display("FAIL lw_pc got=%h want=00000008", pc); end
    endtask

    task automatic test_store();
        int cyc;
        begin_test();
        mem[0] = enc_i('h100, 0, 0, 1, OPC_IMM);
        mem[1] = enc_u('h12345, 3, OPC_LUI);
        mem[2] = enc_i('h6AB, 3, 0, 3, OPC_IMM);
        mem[3] = enc_s(2, 3, 1, 0);
        mem[4] = enc_s(6, 3, 1, 1);
        mem[5] = enc_s(8, 3, 1, 2);
        mem['h40] = 32'h1122_3344;
        mem['h41] = 32'hAAAA_AAAA;
        mem['h42] = 32'h0;
        release_reset();
        repeat (3) wait_retire(20, cyc);
        wait_retire(20, cyc);
        total++; if (cyc != 4) begin bad++; $display("FAIL sb_cycles got=%0d want=4", cyc); end
        total++; if (m_addr !== 32'h102 || m_be !== 4'b0100 || m_we !== 1'b1)
            begin bad++; $display("FAIL sb_req got=%h/%b/%b want=00000102/0100/1", m_addr, m_be, m_we); end
        total++; if (m_wdata !== 32'hABAB_ABAB) begin bad++; $display("FAIL sb_wdata got=%h want=abababab", m_wdata); end
        total++; if (pc !== 32'h10) begin bad++; $display("FAIL sb_pc got=%h want=00000010", pc); end
        wait_retire(20, cyc);
        total++; if (m_addr !== 32'h106 || m_be !== 4'b1100 || m_wdata !== 32'h56AB_56AB)
            begin bad++; $display("FAIL sh_req got=%h/%b/%h want=00000106/1100/56ab56ab", m_addr, m_be, m_wdata); end
        wait_retire(20, cyc);
        total++; if (m_addr !== 32'h108 || m_be !== 4'b1111 || m_wdata !== 32'h1234_56AB)
            begin bad++; $display("FAIL sw_req got=%h/%b/%h want=00000108/1111/123456ab", m_addr, m_be, m_wdata); end
        total++; if (mem['h40] !== 32'h11AB_3344 || mem['h41] !== 32'h56AB_AAAA || mem['h42] !== 32'h1234_56AB)
            begin bad++; $display("FAIL st_mem got=%h %h %h want=11ab3344 56abaaaa 123456ab", mem['h40], mem['h41], mem['h42]); end
    endtask

    task automatic test_load_ext();
        int cyc;
        begin_test();
        mem[0] = enc_i('h100, 0, 0, 1, OPC_IMM);
        mem[1] = enc_i(3, 1, 0, 4, OPC_LOAD);
        mem[2] = enc_i(3, 1, 4, 5, OPC_LOAD);
        mem[3] = enc_i(2, 1, 1, 6, OPC_LOAD);
        mem[4] = enc_i(2, 1, 5, 7, OPC_LOAD);
        mem['h40] = 32'h8011_2233;
        release_reset();
        wait_retire(20, cyc);
        wait_retire(20, cyc);
        total++; if (cyc != 5) begin bad++; $display("FAIL lb_cycles got=%0d want=5", cyc); end
        total++; if (dut.regs[4] !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_val got=%h want=ffffff80", dut.regs[4]); end
        wait_retire(20, cyc);
        total++; if (dut.regs[5] !== 32'h0000_0080) begin bad++; $display("FAIL lbu_val got=%h want=00000080", dut.regs[5]); end
        wait_retire(20, cyc);
        total++; if (dut.regs[6] !== 32'hFFFF_8011) begin bad++; $display("FAIL lh_val got=%h want=ffff8011", dut.regs[6]); end
        fetch_delay = 2;
        wait_retire(20, cyc);
        total++; if (cyc != 7) begin bad++; $display("FAIL lhu_cycles got=%0d want=7", cyc); end
        total++; if (dut.regs[7] !== 32'h0000_8011) begin bad++; $display("FAIL lhu_val got=%h want=00008011", dut.regs[7]); end
    endtask

    task automatic test_branch_jump();
        int cyc;
        begin_test();
        mem[0]  = enc_j('h20, 0);
        mem[6]  = enc_i('h41, 0, 0, 5, OPC_IMM);
        mem[7]  = enc_i(0, 5, 0, 1, OPC_JALR);
        mem[8]  = enc_b(-8, 0, 0, 0);
        mem[16] = enc_b(8, 0, 0, 1);
        mem[17] = enc_j(-'h44, 6);
        release_reset();
        wait_retire(20, cyc);
        total++; if (cyc != 4 || pc !== 32'h20) begin bad++; $display("FAIL jal_x0 got=%0d/%h want=4/00000020", cyc, pc); end
        wait_retire(20, cyc);
        total++; if (cyc != 3 || pc !== 32'h18) begin bad++; $display("FAIL beq_taken got=%0d/%h want=3/00000018", cyc, pc); end
        wait_retire(20, cyc);
        wait_retire(20, cyc);
        total++; if (cyc != 4 || pc !== 32'h40) begin bad++; $display("FAIL jalr_pc got=%0d/%h want=4/00000040", cyc, pc); end
        total++; if (dut.regs[1] !== 32'h20) begin bad++; $display("FAIL jalr_link got=%h want=00000020", dut.regs[1]); end
        wait_retire(20, cyc);
        total++; if (cyc != 3 || pc !== 32'h44) begin bad++; $display("FAIL bne_not_taken got=%0d/%h want=3/00000044", cyc, pc); end
        wait_retire(20, cyc);
        total++; if (pc !== 32'h0 || dut.regs[6] !== 32'h48) begin bad++; $display("FAIL jal_back got=%h/%h want=00000000/00000048", pc, dut.regs[6]); end
    endtask

    task automatic test_trap();
        int cyc;
        bit req_seen, ret_seen;
        logic [2:0] st_at;
        begin_test();
        mem[0] = enc_i('h101, 0, 0, 1, OPC_IMM);
        mem[1] = enc_i(0, 1, 2, 2, OPC_LOAD);
        release_reset();
        wait_retire(20, cyc);
        req_seen = 0; ret_seen = 0; st_at = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk); #1;
            if (c >= 2 && mem_req) req_seen = 1;
            if (retire) ret_seen = 1;
            if (c == 4) st_at = state;
        end
        total++; if (st_at !== 3'd5) begin bad++; $display("FAIL mis_state got=%0d want=5", st_at); end
        total++; if (req_seen || ret_seen) begin bad++; $display("FAIL mis_noreq got=req%b/ret%b want=req0/ret0", req_seen, ret_seen); end
        total++; if (trap !== 1'b1 || pc !== 32'h4) begin bad++; $display("FAIL mis_trap got=%b/%h want=1/00000004", trap, pc); end
        total++; if (dut.regs[2] !== 32'h0) begin bad++; $display("FAIL mis_x2 got=%h want=00000000", dut.regs[2]); end
        begin_test();
        #1;
        total++; if (state !== 3'd0 || pc !== 32'h0 || trap !== 1'b0)
            begin bad++; $display("FAIL trap_reset got=%0d/%h/%b want=0/00000000/0", state, pc, trap); end
        mem[0] = 32'h0000_0073;
        release_reset();
        st_at = '0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); #1;
            if (c == 3) st_at = state;
        end
        total++; if (st_at !== 3'd5 || trap !== 1'b1 || pc !== 32'h0)
            begin bad++; $display("FAIL ecall_trap got=%0d/%b/%h want=5/1/00000000", st_at, trap, pc); end
    endtask

    task automatic test_reset_mid_handshake();
        int cyc;
        int n;
        begin_test();
        mem[0] = enc_i('h100, 0, 0, 1, OPC_IMM);
        mem[1] = enc_i(0, 1, 2, 2, OPC_LOAD);
        data_delay = 5;
        release_reset();
        wait_retire(20, cyc);
        n = 0;
        while (!(state == 3'd3 && mem_req) && n < 12) begin
            @(negedge clk); #1;
            n++;
        end
        total++; if (state !== 3'd3) begin bad++; $display("FAIL mid_reach got=%0d want=3", state); end
        #2 reset = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0 || state !== 3'd0 || pc !== 32'h0)
            begin bad++; $display("FAIL mid_reset got=%b/%0d/%h want=0/0/00000000", mem_req, state, pc); end
        total++; if (dut.regs[1] !== 32'h0) begin bad++; $display("FAIL mid_regs got=%h want=00000000", dut.regs[1]); end
        data_delay = 0;
        release_reset();
        wait_retire(20, cyc);
        total++; if (cyc != 4 || pc !== 32'h4 || dut.regs[1] !== 32'h100)
            begin bad++; $display("FAIL mid_restart got=%0d/%h/%h want=4/00000004/00000100", cyc, pc, dut.regs[1]); end
    endtask

    initial begin
        reset       = 1'b1;
        fetch_delay = 0;
        data_delay  = 0;
        test_reset();
        test_addi();
        test_load_delay();
        test_store();
        test_load_ext();
        test_branch_jump();
        test_trap();
        test_reset_mid_handshake();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
